// File: rtl/pwm_dac_pkg.sv
// Shared PWM DAC constants and config-word layout, also used by the AMS config encoder.
package pwm_dac_pkg;

    localparam int DUTY_W    = 8;
    localparam int PAT_W     = 16;
    localparam int CCW       = DUTY_W + PAT_W;
    localparam int IDX_W     = $clog2(PAT_W);

    // Field positions inside the configuration word.
    localparam int DUTY_LSB  = PAT_W;
    localparam int PAT_MSB   = PAT_W - 1;

    // Pattern MSB is applied in period 0, LSB in the last period of the frame.
    localparam bit MSB_FIRST = 1'b1;

    typedef logic [DUTY_W-1:0] duty_t;
    typedef logic [PAT_W-1:0]  pat_t;
    typedef logic [CCW-1:0]    cfg_word_t;

    typedef struct packed {
        duty_t duty;
        pat_t  pat;
    } cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_st_e;

    function automatic cfg_word_t pack_cfg(input duty_t duty, input pat_t pat);
        cfg_t c;
        c.duty = duty;
        c.pat  = pat;
        return cfg_word_t'(c);
    endfunction

    // High clocks per frame; mean duty = this / (2**DUTY_W * PAT_W).
    function automatic int frame_high_clks(input duty_t duty, input pat_t pat);
        return int'(duty) * PAT_W + $countones(pat);
    endfunction

endpackage

// File: rtl/pwm_dither_dac_if.sv
// Enable/config in, PWM bit and period/frame strobes out.
interface pwm_dither_dac_if #(
    parameter int CCW = pwm_dac_pkg::CCW
);
    logic           en_i;
    logic [CCW-1:0] cfg_i;
    logic           pwm_o;
    logic           cycle_o;
    logic           frame_o;

    modport master (
        output en_i, cfg_i,
        input  pwm_o, cycle_o, frame_o
    );

    modport slave (
        input  en_i, cfg_i,
        output pwm_o, cycle_o, frame_o
    );
endinterface

// File: rtl/pwm_frame_cnt.sv
// Period counter, frame index, run state and the registered period/frame strobes.
module pwm_frame_cnt #(
    parameter int DUTY_W = pwm_dac_pkg::DUTY_W,
    parameter int PAT_W  = pwm_dac_pkg::PAT_W,
    parameter int IDX_W  = $clog2(PAT_W)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    output logic [DUTY_W-1:0] cnt_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              act_o,
    output logic              fstart_o,
    output logic              cycle_o,
    output logic              frame_o
);
    import pwm_dac_pkg::*;

    run_st_e           r_state;
    run_st_e           w_state_nxt;
    logic [DUTY_W-1:0] r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_cycle;
    logic              r_frame;
    logic              w_act;
    logic              w_pstart;
    logic              w_fstart;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Dropping en_i stops on the same edge; rising en_i spends one clock entering RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en_i)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!en_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_act    = (r_state == ST_RUN) && en_i;
    assign w_pstart = w_act && (r_cnt == '0);
    assign w_fstart = w_pstart && (r_idx == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_cycle <= 1'b0;
            r_frame <= 1'b0;
        end else if (!w_act) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_cycle <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            if (&r_cnt) r_idx <= r_idx + 1'b1;
            r_cycle <= w_pstart;
            r_frame <= w_fstart;
        end
    end

    assign cnt_o    = r_cnt;
    assign idx_o    = r_idx;
    assign act_o    = w_act;
    assign fstart_o = w_fstart;
    assign cycle_o  = r_cycle;
    assign frame_o  = r_frame;

endmodule

// File: rtl/pwm_dither_dac.sv
// Dithered PWM DAC: frame-aligned shadow config, per-period dither bit, registered compare.
module pwm_dither_dac #(
    parameter int DUTY_W = pwm_dac_pkg::DUTY_W,
    parameter int PAT_W  = pwm_dac_pkg::PAT_W,
    parameter int CCW    = DUTY_W + PAT_W
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    pwm_dither_dac_if.slave bus
);
    import pwm_dac_pkg::*;

    localparam int               IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    logic [DUTY_W-1:0] r_duty;
    logic [PAT_W-1:0]  r_pat;
    logic              r_pwm;

    logic [DUTY_W-1:0] w_cnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_act;
    logic              w_fstart;
    logic [DUTY_W-1:0] w_duty;
    logic [PAT_W-1:0]  w_pat;
    logic [IDX_W-1:0]  w_sel;
    logic              w_dbit;
    logic              w_hi;

    pwm_frame_cnt #(
        .DUTY_W (DUTY_W),
        .PAT_W  (PAT_W),
        .IDX_W  (IDX_W)
    ) u_frame_cnt (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (bus.en_i),
        .cnt_o    (w_cnt),
        .idx_o    (w_idx),
        .act_o    (w_act),
        .fstart_o (w_fstart),
        .cycle_o  (bus.cycle_o),
        .frame_o  (bus.frame_o)
    );

    // On the frame-start clock the compare must already see the new word.
    assign w_duty = w_fstart ? bus.cfg_i[CCW-1:PAT_W] : r_duty;
    assign w_pat  = w_fstart ? bus.cfg_i[PAT_W-1:0]   : r_pat;

    assign w_sel  = MSB_FIRST ? (IDX_LAST - w_idx) : w_idx;
    assign w_dbit = w_pat[w_sel];

    // One extra bit so duty 2**DUTY_W-1 plus dither reaches a full-high period.
    assign w_hi   = ({1'b0, w_cnt} < ({1'b0, w_duty} + {{DUTY_W{1'b0}}, w_dbit}));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_duty <= '0;
            r_pat  <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (w_fstart) begin
                r_duty <= bus.cfg_i[CCW-1:PAT_W];
                r_pat  <= bus.cfg_i[PAT_W-1:0];
            end
            r_pwm <= w_act && w_hi;
        end
    end

    assign bus.pwm_o = r_pwm;

endmodule
